// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_pkg                                                                   |
// | Shared helpers for the multi-bank FWFT FIFO: width function, bank-select   |
// | type, minimum bank count and parameter legality test.                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package fifo_pkg;

  localparam int MIN_BANKS = 2;

  // Wide enough for any legal bank index (up to 256 banks).
  typedef logic [7:0] bank_sel_t;

  // ceil(log2(n)), but never below 1 so that vectors never collapse to zero width.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Returns 1 when the FIFO geometry is one the datapath can implement.
  function automatic bit params_legal(input int depth, input int banks, input int aw);
    return is_pow2(depth) && is_pow2(banks) && (banks >= MIN_BANKS) &&
           (banks <= 256) && ((depth % banks) == 0) && (depth >= banks) &&
           ((1 << aw) == depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_spram_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_spram_bank                                                            |
// | One bank of the interleaved FWFT FIFO: a single-port RAM plus a one-entry  |
// | head register. A RAM write always wins the single port; a pending head     |
// | refill simply waits one cycle.                                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fifo_spram_bank
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 16,
  parameter int BANK_AW    = clog2_min1(BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [BANK_AW-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam logic [BANK_AW:0]   CNT_ONE  = (BANK_AW + 1)'(1);
  localparam logic [BANK_AW-1:0] ADDR_ONE = BANK_AW'(1);

  logic [DATA_WIDTH-1:0] mem [0:(1 << BANK_AW)-1];
  logic                  head_valid;
  logic [BANK_AW-1:0]    rd_addr;   // in-bank address of the next entry to enter the head
  logic [BANK_AW:0]      ram_cnt;   // entries held in RAM, not counting the head

  logic ram_empty;
  logic load_direct;
  logic ram_wr;
  logic refill;

  // Port arbitration: direct head load bypasses RAM, a RAM write owns the port,
  // otherwise the port is free to refill the head (on the pop edge or later).
  always_comb begin
    ram_empty   = (ram_cnt == '0);
    load_direct = push && !head_valid && ram_empty;
    ram_wr      = push && !load_direct;
    refill      = !ram_wr && !ram_empty && (!head_valid || pop);
  end

  // RAM write port (contents need no reset).
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_addr] <= wdata;
  end

  // Head register, its valid bit and the refill address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data  <= '0;
      head_valid <= 1'b0;
      rd_addr    <= '0;
    end else if (load_direct) begin
      head_data  <= wdata;
      head_valid <= 1'b1;
      rd_addr    <= rd_addr + ADDR_ONE;
    end else if (refill) begin
      head_data  <= mem[rd_addr];
      head_valid <= 1'b1;
      rd_addr    <= rd_addr + ADDR_ONE;
    end else if (pop) begin
      head_valid <= 1'b0;
    end
  end

  // RAM occupancy: up on a RAM write, down when an entry moves into the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cnt <= '0;
    end else begin
      case ({ram_wr, refill})
        2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
        2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_fwft_mbank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_fwft_mbank                                                            |
// | First-word-fall-through FIFO interleaved round-robin across NUM_BANKS      |
// | single-port RAM banks, with occupancy count and sticky error flags.        |
// | Optional feature macro: FIFO_MB_PROG_FLAGS_EN adds registered almost-full  |
// | / almost-empty outputs (afull_o, aempty_o).                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module fifo_fwft_mbank
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
`ifdef FIFO_MB_PROG_FLAGS_EN
  ,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  input  logic                  ren_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  rvalid_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  ovf_o,
  output logic                  udf_o,
  input  logic                  clr_err_i
`ifdef FIFO_MB_PROG_FLAGS_EN
  ,
  output logic                  afull_o,
  output logic                  aempty_o
`endif
);

  localparam int BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int BANK_DEPTH = FIFO_DEPTH / NUM_BANKS;
  localparam int BANK_AW    = clog2_min1(BANK_DEPTH);

  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  if (!params_legal(FIFO_DEPTH, NUM_BANKS, ADDR_WIDTH)) begin : g_param_check
    $error("fifo_fwft_mbank: illegal FIFO_DEPTH/NUM_BANKS/ADDR_WIDTH combination");
  end

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [BANK_AW-1:0]    wr_addr;
  bank_sel_t             rd_sel;
  logic [NUM_BANKS-1:0]  bank_push;
  logic [NUM_BANKS-1:0]  bank_pop;
  logic [DATA_WIDTH-1:0] head_data [NUM_BANKS];
  logic [DATA_WIDTH-1:0] head_mux;

  // Acceptance is judged purely on the pre-edge flags.
  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    push    = wen_i && !full;
    pop     = ren_i && !empty;
    wr_addr = BANK_AW'(wptr >> BANK_SEL_W);
    rd_sel  = bank_sel_t'(rptr[BANK_SEL_W-1:0]);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_push[b] = push && (wptr[BANK_SEL_W-1:0] == BANK_SEL_W'(b));
    assign bank_pop[b]  = pop  && (rptr[BANK_SEL_W-1:0] == BANK_SEL_W'(b));

    fifo_spram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .BANK_DEPTH (BANK_DEPTH),
      .BANK_AW    (BANK_AW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (bank_push[b]),
      .wr_addr   (wr_addr),
      .wdata     (wdata_i),
      .pop       (bank_pop[b]),
      .head_data (head_data[b])
    );
  end

  // Select the head of the bank the read pointer currently addresses.
  always_comb begin
    head_mux = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_sel == bank_sel_t'(i)) head_mux = head_data[i];
    end
  end

  // Next occupancy: simultaneous accepted push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + PTR_ONE;
    else if (pop && !push) count_nxt = count - PTR_ONE;
  end

  // Pointers and occupancy; pointers wrap modulo 2*FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      ovf_o <= (wen_i && full)  || (ovf_o && !clr_err_i);
      udf_o <= (ren_i && empty) || (udf_o && !clr_err_i);
    end
  end

`ifdef FIFO_MB_PROG_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(AE_LEVEL);

  // Programmable flags registered from the next-state occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_o  <= 1'b0;
      aempty_o <= 1'b1;
    end else begin
      afull_o  <= (count_nxt >= AF_CNT);
      aempty_o <= (count_nxt <= AE_CNT);
    end
  end
`endif

  assign count_o  = count;
  assign full_o   = full;
  assign empty_o  = empty;
  assign rvalid_o = !empty;
  assign rdata_o  = empty ? '0 : head_mux;

endmodule
`default_nettype wire
